// File: rtl/gcn_ctrl_pkg.sv
// Shared types and constants for the GCN combination-stage read control.
package gcn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_W    = 3'd1,
    RD_F    = 3'd2,
    WAIT_F  = 3'd3,
    COMPUTE = 3'd4,
    FIN     = 3'd5
  } sched_state_t;

  localparam int                    ADDR_WIDTH        = 13;
  localparam logic [ADDR_WIDTH-1:0] FEATURE_BASE_ADDR = 13'd512;

  // Address the external generator produces for a given region/index.
  function automatic logic [ADDR_WIDTH-1:0] read_addr(input logic is_feature,
                                                      input int unsigned index);
    read_addr = is_feature ? FEATURE_BASE_ADDR + ADDR_WIDTH'(index) : ADDR_WIDTH'(index);
  endfunction

endpackage

// File: rtl/read_latency_pipe.sv
// Delay line that tracks each memory read until its data is valid.
// Weight and feature reads share it, so they retire in issue order.
module read_latency_pipe #(
  parameter int DEPTH     = 1,
  parameter int IDX_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_i,
  input  logic                 is_feature_i,
  input  logic [IDX_WIDTH-1:0] idx_i,
  output logic                 valid_o,
  output logic                 is_feature_o,
  output logic [IDX_WIDTH-1:0] idx_o
);

  typedef struct packed {
    logic                 valid;
    logic                 is_feature;
    logic [IDX_WIDTH-1:0] idx;
  } stage_t;

  stage_t stage_q [DEPTH];

  // Shift reads down the line; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= '{valid: valid_i, is_feature: is_feature_i, idx: idx_i};
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign valid_o      = stage_q[DEPTH-1].valid;
  assign is_feature_o = stage_q[DEPTH-1].is_feature;
  assign idx_o        = stage_q[DEPTH-1].idx;

endmodule

// File: rtl/gcn_read_scheduler.sv
// Sequences the shared feature/weight read port: all weight columns first,
// then one feature row at a time, handing each row to the compute array.
//
//   state   | meaning
//   IDLE    | counters at 0, waiting for start
//   RD_W    | one weight-column read per cycle
//   RD_F    | single read of the current feature row
//   WAIT_F  | waiting for the feature word to come out of memory
//   COMPUTE | row handed over, waiting for compute_done
//   FIN     | one-cycle done pulse
module gcn_read_scheduler
  import gcn_ctrl_pkg::*;
#(
  parameter int WEIGHT_COLS           = 3,
  parameter int COUNTER_WEIGHT_WIDTH  = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1,
  parameter int FEATURE_ROWS          = 6,
  parameter int COUNTER_FEATURE_WIDTH = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1,
  parameter int MEM_READ_LATENCY      = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             compute_done,
  output logic                             enable_read,
  output logic                             enable_feature,
  output logic [COUNTER_FEATURE_WIDTH-1:0] feature_count,
  output logic [COUNTER_WEIGHT_WIDTH-1:0]  weight_count,
  output logic                             weight_wr_en,
  output logic [COUNTER_WEIGHT_WIDTH-1:0]  weight_wr_idx,
  output logic                             feature_wr_en,
  output logic                             start_compute,
  output logic                             busy,
  output logic                             done
);

  localparam logic [COUNTER_WEIGHT_WIDTH-1:0]  WC_LAST = COUNTER_WEIGHT_WIDTH'(WEIGHT_COLS - 1);
  localparam logic [COUNTER_FEATURE_WIDTH-1:0] FC_LAST = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);

  sched_state_t                     state_q, state_d;
  logic [COUNTER_WEIGHT_WIDTH-1:0]  wc_q, wc_d;
  logic [COUNTER_FEATURE_WIDTH-1:0] fc_q, fc_d;
  logic                             en_read_q, en_feat_q, sc_q, busy_q, done_q;
  logic                             pipe_valid, pipe_is_feature;
  logic [COUNTER_WEIGHT_WIDTH-1:0]  pipe_idx;

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    fc_d    = fc_q;
    case (state_q)
      IDLE: begin
        wc_d = '0;
        fc_d = '0;
        if (start) state_d = RD_W;
      end
      RD_W: begin
        if (wc_q == WC_LAST) begin
          wc_d    = '0;
          state_d = RD_F;
        end else begin
          wc_d = wc_q + COUNTER_WEIGHT_WIDTH'(1);
        end
      end
      RD_F: state_d = WAIT_F;
      WAIT_F: begin
        if (pipe_valid && pipe_is_feature) state_d = COMPUTE;
      end
      COMPUTE: begin
        if (compute_done) begin
          if (fc_q == FC_LAST) begin
            fc_d    = '0;
            state_d = FIN;
          end else begin
            fc_d    = fc_q + COUNTER_FEATURE_WIDTH'(1);
            state_d = RD_F;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and outputs; outputs are decoded from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wc_q      <= '0;
      fc_q      <= '0;
      en_read_q <= 1'b0;
      en_feat_q <= 1'b0;
      sc_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wc_q      <= wc_d;
      fc_q      <= fc_d;
      en_read_q <= (state_d == RD_W) || (state_d == RD_F);
      en_feat_q <= (state_d == RD_F);
      sc_q      <= (state_q == WAIT_F) && (state_d == COMPUTE);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == FIN);
    end
  end

  read_latency_pipe #(
    .DEPTH    (MEM_READ_LATENCY),
    .IDX_WIDTH(COUNTER_WEIGHT_WIDTH)
  ) u_pipe (
    .clk         (clk),
    .reset       (reset),
    .valid_i     (en_read_q),
    .is_feature_i(en_feat_q),
    .idx_i       (wc_q),
    .valid_o     (pipe_valid),
    .is_feature_o(pipe_is_feature),
    .idx_o       (pipe_idx)
  );

  assign enable_read    = en_read_q;
  assign enable_feature = en_feat_q;
  assign feature_count  = fc_q;
  assign weight_count   = wc_q;
  assign weight_wr_en   = pipe_valid & ~pipe_is_feature;
  assign feature_wr_en  = pipe_valid & pipe_is_feature;
  assign weight_wr_idx  = pipe_idx;
  assign start_compute  = sc_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_gcn_read_scheduler.sv
// Bench for gcn_read_scheduler: a default instance (3 cols, 6 rows, latency 1)
// and a minimal instance (1 col, 1 row, latency 3).
module tb_gcn_read_scheduler;

  typedef struct packed {
    logic       er;
    logic       ef;
    logic [2:0] fc;
    logic [1:0] wc;
    logic       wwe;
    logic [1:0] widx;
    logic       fwe;
    logic       sc;
    logic       busy;
    logic       done;
  } vec_t;

  typedef struct {
    logic start;
    logic cd;
    vec_t exp;
  } row_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_a, cd_a, start_b, cd_b;
  logic er_a, ef_a, wwe_a, fwe_a, sc_a, busy_a, done_a;
  logic [2:0] fc_a;
  logic [1:0] wc_a, widx_a;
  logic er_b, ef_b, wwe_b, fwe_b, sc_b, busy_b, done_b;
  logic [0:0] fc_b, wc_b, widx_b;

  gcn_read_scheduler dut_a (
    .clk(clk), .reset(reset), .start(start_a), .compute_done(cd_a),
    .enable_read(er_a), .enable_feature(ef_a), .feature_count(fc_a),
    .weight_count(wc_a), .weight_wr_en(wwe_a), .weight_wr_idx(widx_a),
    .feature_wr_en(fwe_a), .start_compute(sc_a), .busy(busy_a), .done(done_a)
  );

  gcn_read_scheduler #(
    .WEIGHT_COLS(1), .FEATURE_ROWS(1), .MEM_READ_LATENCY(3)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .compute_done(cd_b),
    .enable_read(er_b), .enable_feature(ef_b), .feature_count(fc_b),
    .weight_count(wc_b), .weight_wr_en(wwe_b), .weight_wr_idx(widx_b),
    .feature_wr_en(fwe_b), .start_compute(sc_b), .busy(busy_b), .done(done_b)
  );

  int checks   = 0;
  int failures = 0;

  // Reference timeline of one pass, built from the read/compute schedule.
  vec_t exp_v   [0:255];
  logic cd_v    [0:255];
  logic comp_v  [0:255];
  int   comp_first [0:7];
  int   cdel    [0:7];
  int   exp_len;
  int   model_rows;
  int   last_done_at;

  task automatic build_model(input int W, input int R, input int L);
    int base, len, first;
    for (int k = 0; k < 256; k++) begin
      exp_v[k] = '0; cd_v[k] = 1'b0; comp_v[k] = 1'b0;
    end
    for (int k = 0; k < W; k++) begin
      exp_v[k].er = 1'b1; exp_v[k].wc = 2'(k); exp_v[k].busy = 1'b1;
    end
    for (int k = 0; k < W; k++) begin
      exp_v[k+L].wwe = 1'b1; exp_v[k+L].widx = 2'(k);
    end
    base = W;
    for (int r = 0; r < R; r++) begin
      len = 2 + L + cdel[r];
      for (int j = 0; j < len; j++) begin
        exp_v[base+j].fc = 3'(r); exp_v[base+j].busy = 1'b1;
      end
      exp_v[base].er = 1'b1; exp_v[base].ef = 1'b1;
      exp_v[base+L].fwe = 1'b1;
      first = base + L + 1;
      exp_v[first].sc = 1'b1;
      comp_first[r] = first;
      for (int j = first; j <= first + cdel[r]; j++) comp_v[j] = 1'b1;
      cd_v[first+cdel[r]] = 1'b1;
      base += len;
    end
    exp_v[base].done = 1'b1; exp_v[base].busy = 1'b1;
    exp_len = base + 1;
    model_rows = R;
  endtask

  function automatic vec_t actual(input int sel);
    vec_t v;
    if (sel == 0)
      v = '{er: er_a, ef: ef_a, fc: fc_a, wc: wc_a, wwe: wwe_a,
            widx: (wwe_a ? widx_a : 2'd0), fwe: fwe_a, sc: sc_a, busy: busy_a, done: done_a};
    else
      v = '{er: er_b, ef: ef_b, fc: {2'b00, fc_b}, wc: {1'b0, wc_b}, wwe: wwe_b,
            widx: (wwe_b ? {1'b0, widx_b} : 2'd0), fwe: fwe_b, sc: sc_b, busy: busy_b, done: done_b};
    return v;
  endfunction

  function automatic vec_t mk(input logic er, input logic ef, input logic wwe, input logic fwe,
                              input logic sc, input logic busy, input logic done);
    vec_t v;
    v = '0;
    v.er = er; v.ef = ef; v.wwe = wwe; v.fwe = fwe; v.sc = sc; v.busy = busy; v.done = done;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int sel, input logic s, input logic c);
    if (sel == 0) begin start_a = s; cd_a = c; end
    else begin start_b = s; cd_b = c; end
  endtask

  task automatic check_vec(input string name, input int cyc, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%b expected=%b (er ef fc wc wwe widx fwe sc busy done)",
               name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Runs one pass against the reference timeline. cd_mode: 0 exact pulses,
  // 1 plus random pulses outside COMPUTE, 2 compute_done held high.
  task automatic run_pass(input int sel, input bit skip_start, input bit hold_start,
                          input int cd_mode, input int sb_cycle);
    int   dn, scn;
    logic c;
    vec_t act;
    dn = 0; scn = 0; last_done_at = -1;
    if (!skip_start) begin
      set_in(sel, 1'b1, 1'b0);
      tick();
    end
    for (int k = 0; k < exp_len; k++) begin
      c = cd_v[k];
      if (cd_mode == 2) c = 1'b1;
      if (cd_mode == 1 && !comp_v[k] && $urandom_range(0, 3) == 0) c = 1'b1;
      set_in(sel, hold_start ? 1'b1 : (k == sb_cycle), c);
      @(negedge clk);
      act = actual(sel);
      check_vec("pass", k, act, exp_v[k]);
      dn  += int'(act.done);
      scn += int'(act.sc);
      if (act.done && last_done_at < 0) last_done_at = k + 1;
      tick();
    end
    set_in(sel, hold_start, 1'b0);
    @(negedge clk);
    check_vec("idle_after", exp_len, actual(sel), '0);
    check_int("done_pulses", dn, 1);
    check_int("start_compute_pulses", scn, model_rows);
    tick();
  endtask

  row_t tbl [10];

  initial begin
    reset = 1'b1;
    start_a = 1'b0; cd_a = 1'b0; start_b = 1'b0; cd_b = 1'b0;

    // Minimal instance: start, stray compute_done in WAIT_F, start while busy.
    tbl[0] = '{start: 1'b1, cd: 1'b0, exp: '0};
    tbl[1] = '{start: 1'b0, cd: 1'b0, exp: mk(1, 0, 0, 0, 0, 1, 0)};
    tbl[2] = '{start: 1'b0, cd: 1'b0, exp: mk(1, 1, 0, 0, 0, 1, 0)};
    tbl[3] = '{start: 1'b0, cd: 1'b1, exp: mk(0, 0, 0, 0, 0, 1, 0)};
    tbl[4] = '{start: 1'b1, cd: 1'b0, exp: mk(0, 0, 1, 0, 0, 1, 0)};
    tbl[5] = '{start: 1'b0, cd: 1'b0, exp: mk(0, 0, 0, 1, 0, 1, 0)};
    tbl[6] = '{start: 1'b0, cd: 1'b0, exp: mk(0, 0, 0, 0, 1, 1, 0)};
    tbl[7] = '{start: 1'b0, cd: 1'b1, exp: mk(0, 0, 0, 0, 0, 1, 0)};
    tbl[8] = '{start: 1'b0, cd: 1'b0, exp: mk(0, 0, 0, 0, 0, 1, 1)};
    tbl[9] = '{start: 1'b0, cd: 1'b0, exp: '0};

    tick(); tick(); tick();
    @(negedge clk);
    check_vec("reset_a", 0, actual(0), '0);
    check_vec("reset_b", 0, actual(1), '0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      set_in(1, tbl[i].start, tbl[i].cd);
      @(negedge clk);
      check_vec("table_small", i, actual(1), tbl[i].exp);
      tick();
    end

    // compute_done two cycles after every start_compute.
    for (int r = 0; r < 8; r++) cdel[r] = 2;
    build_model(3, 6, 1);
    run_pass(0, 1'b0, 1'b0, 0, -1);
    check_int("pass_len_c2", last_done_at, 34);

    // compute_done held high: one cycle per row in COMPUTE.
    for (int r = 0; r < 8; r++) cdel[r] = 0;
    build_model(3, 6, 1);
    run_pass(0, 1'b0, 1'b0, 2, -1);
    check_int("pass_len_held", last_done_at, 22);
    set_in(0, 1'b0, 1'b0);

    // start pulsed in the first COMPUTE cycle of row 3.
    for (int r = 0; r < 8; r++) cdel[r] = 1;
    build_model(3, 6, 1);
    run_pass(0, 1'b0, 1'b0, 0, comp_first[3]);

    // Reset while weight_count = 1.
    set_in(0, 1'b1, 1'b0);
    tick();
    set_in(0, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    check_int("pre_reset_wc", int'(wc_a), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_vec("reset_mid_rdw", 0, actual(0), '0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      @(negedge clk);
      check_vec("post_reset_quiet", i, actual(0), '0);
    end
    tick();

    // start held high through FIN, then a second pass begins immediately.
    for (int r = 0; r < 8; r++) cdel[r] = 1;
    build_model(3, 6, 1);
    run_pass(0, 1'b0, 1'b1, 0, -1);
    build_model(3, 6, 1);
    run_pass(0, 1'b1, 1'b0, 0, -1);

    // Randomized passes on both instances.
    for (int p = 0; p < 8; p++) begin
      for (int r = 0; r < 8; r++) cdel[r] = int'($urandom_range(0, 4));
      build_model(3, 6, 1);
      run_pass(0, 1'b0, 1'b0, 1, int'($urandom_range(0, exp_len - 2)));
    end
    for (int p = 0; p < 3; p++) begin
      for (int r = 0; r < 8; r++) cdel[r] = int'($urandom_range(0, 4));
      build_model(1, 1, 3);
      run_pass(1, 1'b0, 1'b0, 1, int'($urandom_range(0, exp_len - 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gcn_read_scheduler.md
Name: gcn_read_scheduler

Overview:
- Sequences the shared feature/weight memory read port for the combination (transformation) stage.
- Reads all weight columns first. Then, for each feature row, it reads that row and hands it to the compute array.
- Drives the address-generation inputs (enable_feature, feature_count, weight_count). The address generator maps features to address 512+row and weights to address 0+col.
- Handshakes with the compute array: start_compute / compute_done.

Parameters:
- WEIGHT_COLS, 3, number of weight columns (one memory word each).
- COUNTER_WEIGHT_WIDTH, $clog2(WEIGHT_COLS), width of weight_count.
- FEATURE_ROWS, 6, number of feature rows (one memory word each).
- COUNTER_FEATURE_WIDTH, $clog2(FEATURE_ROWS), width of feature_count.
- MEM_READ_LATENCY, 1, cycles from address presented to data valid (supported values 1..3).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin one full pass; sampled only in IDLE.
- compute_done  input  1  one-cycle pulse from the compute array when the current row has been processed.
- enable_read  output  1  memory read enable.
- enable_feature  output  1  1 = feature region, 0 = weight region (to the address generator).
- feature_count  output  COUNTER_FEATURE_WIDTH  current feature row index.
- weight_count  output  COUNTER_WEIGHT_WIDTH  current weight column index.
- weight_wr_en  output  1  memory data is a weight word; write it into weight buffer slot weight_wr_idx.
- weight_wr_idx  output  COUNTER_WEIGHT_WIDTH  weight_count delayed by MEM_READ_LATENCY.
- feature_wr_en  output  1  memory data is a feature word; latch it into the row register.
- start_compute  output  1  one-cycle pulse: row register and weight buffer are valid.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the last row's compute_done has been accepted.

Behaviour:
- All outputs and counters are registered. Reset value of every output is 0; the state resets to IDLE.
- Reset asserted in any state aborts the pass on the next edge. The delay pipeline is flushed, so no *_wr_en is issued after reset.
- States: IDLE, RD_W, RD_F, WAIT_F, COMPUTE, FIN.
- IDLE:
  - Counters are held at 0; enable_read = 0.
  - start = 1 -> RD_W.
- RD_W:
  - enable_read = 1, enable_feature = 0.
  - weight_count increments every cycle, from 0 to WEIGHT_COLS-1.
  - At WEIGHT_COLS-1: weight_count returns to 0 -> RD_F.
  - Exactly WEIGHT_COLS consecutive read cycles occur.
- RD_F:
  - enable_read = 1, enable_feature = 1 for exactly one cycle -> WAIT_F.
- WAIT_F:
  - enable_read = 0.
  - Wait until the delayed feature_wr_en has fired, then -> COMPUTE. start_compute is asserted in the cycle after feature_wr_en.
  - The weight and feature pipelines share one delay line. The final weight write therefore always precedes feature_wr_en.
- COMPUTE:
  - start_compute is high for the first cycle only.
  - Hold until compute_done = 1.
  - If feature_count == FEATURE_ROWS-1: feature_count returns to 0 -> FIN.
  - Otherwise: feature_count increments -> RD_F.
- FIN: done = 1 for one cycle -> IDLE. busy drops in the same edge.
- Handshake edge cases:
  - compute_done outside COMPUTE is ignored.
  - compute_done coincident with start_compute is accepted; this gives a minimum row time of 1 cycle in COMPUTE.
  - start while busy is ignored; no restart occurs.
  - start held high at FIN -> a new pass begins from IDLE on the following cycle.
- Delay line:
  - MEM_READ_LATENCY stages of {valid, is_feature, weight_idx}.
  - weight_wr_en = valid & ~is_feature; feature_wr_en = valid & is_feature.
- Counter compares use the full counter width. WEIGHT_COLS = 1 or FEATURE_ROWS = 1 must work: a single read, with the counter staying at 0.
- Pass length (cycles from start accepted to done), with L = MEM_READ_LATENCY and compute_done returned C cycles after start_compute:
  - WEIGHT_COLS + FEATURE_ROWS*(1 + L + 1 + C) + 1, approximately.
  - The bench checks exact counts for L = 1.

Decomposition:
- Package gcn_ctrl_pkg: state enum sched_state_t (IDLE, RD_W, RD_F, WAIT_F, COMPUTE, FIN), FEATURE_BASE_ADDR = 512, address width 13.
- One sub-module, read_latency_pipe: parameterised delay line for {valid, is_feature, idx}, with synchronous clear on reset.
- The existing address generator is instantiated beside this block, not inside it.

Test Plan:
- Reset mid-RD_W (weight_count = 1, default params) -> next cycle: all outputs 0, state IDLE, no weight_wr_en pulse afterwards.
- start with defaults, compute_done returned 2 cycles after each start_compute:
  - Reads issued in order W0, W1, W2, F0; F1 … F5 follow, one per row.
  - weight_wr_idx is 0, 1, 2 one cycle after each weight read.
  - 6 start_compute pulses, done after the 6th compute_done, done asserted exactly once.
- compute_done held high continuously -> each row spends exactly 1 cycle in COMPUTE, and no row is skipped or repeated.
- start pulsed during COMPUTE of row 3 -> ignored: feature_count continues 4, 5, and only one done pulse occurs.
- Parameters WEIGHT_COLS = 1, FEATURE_ROWS = 1, MEM_READ_LATENCY = 3:
  - One weight read, then one feature read.
  - feature_wr_en arrives 3 cycles after the feature read, and start_compute follows it 1 cycle later.
- start held high through FIN -> done pulse, one IDLE cycle, then a second pass begins with weight_count = 0.
